// File: rtl/multiexp_job_arbiter_pkg.sv
// Shared types and helpers for the multiexp job arbiter.
// Holds the sequencer state encoding, the element-counter width and the
// round-robin pointer wrap helper used by the top and its arbiter.
package multiexp_job_arbiter_pkg;

    localparam int CNT_BITS = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_ZERO     = 2'd3
    } state_t;

    // Index after idx, wrapping back to 0 at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/multiexp_job_arbiter_if.sv
// Bundle of every handshake/data signal between requesters, the arbiter and
// the multiexp engine. master = arbiter view, slave = environment view
// (requesters + engine). Per-requester vectors are packed, slice r at [r*W +: W].
interface multiexp_job_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int SCL_BITS = 256,
    parameter int PNT_BITS = 512,
    parameter int RES_BITS = 512
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // job requests
    logic [NUM_REQ-1:0]          job_val;
    logic [NUM_REQ*64-1:0]       job_num;
    logic [NUM_REQ-1:0]          job_rdy;
    // requester scalar / point streams
    logic [NUM_REQ-1:0]          scl_val;
    logic [NUM_REQ*SCL_BITS-1:0] scl_dat;
    logic [NUM_REQ-1:0]          scl_rdy;
    logic [NUM_REQ-1:0]          pnt_val;
    logic [NUM_REQ*PNT_BITS-1:0] pnt_dat;
    logic [NUM_REQ-1:0]          pnt_rdy;
    // engine side
    logic [63:0]                 num_in;
    logic                        eng_scl_val;
    logic [SCL_BITS-1:0]         eng_scl_dat;
    logic                        eng_scl_rdy;
    logic                        eng_pnt_val;
    logic [PNT_BITS-1:0]         eng_pnt_dat;
    logic                        eng_pnt_rdy;
    logic                        eng_res_val;
    logic [RES_BITS-1:0]         eng_res_dat;
    logic                        eng_res_sop;
    logic                        eng_res_eop;
    logic                        eng_res_rdy;
    // result back to requesters (val one-hot, payload shared)
    logic [NUM_REQ-1:0]          res_val;
    logic [RES_BITS-1:0]         res_dat;
    logic                        res_sop;
    logic                        res_eop;
    logic [NUM_REQ-1:0]          res_rdy;
    // status
    logic                        busy;
    logic [IDX_W-1:0]            owner;

    modport master (
        input  job_val, job_num,
        output job_rdy,
        input  scl_val, scl_dat,
        output scl_rdy,
        input  pnt_val, pnt_dat,
        output pnt_rdy,
        output num_in,
        output eng_scl_val, eng_scl_dat,
        input  eng_scl_rdy,
        output eng_pnt_val, eng_pnt_dat,
        input  eng_pnt_rdy,
        input  eng_res_val, eng_res_dat, eng_res_sop, eng_res_eop,
        output eng_res_rdy,
        output res_val, res_dat, res_sop, res_eop,
        input  res_rdy,
        output busy, owner
    );

    modport slave (
        output job_val, job_num,
        input  job_rdy,
        output scl_val, scl_dat,
        input  scl_rdy,
        output pnt_val, pnt_dat,
        input  pnt_rdy,
        input  num_in,
        input  eng_scl_val, eng_scl_dat,
        output eng_scl_rdy,
        input  eng_pnt_val, eng_pnt_dat,
        output eng_pnt_rdy,
        output eng_res_val, eng_res_dat, eng_res_sop, eng_res_eop,
        input  eng_res_rdy,
        input  res_val, res_dat, res_sop, res_eop,
        output res_rdy,
        input  busy, owner
    );

endinterface

// File: rtl/multiexp_job_arbiter_rr_arbiter.sv
// Round-robin pick: first set bit of req searching upward from ptr with wrap.
// Latency: purely combinational. Backpressure: none, caller qualifies the grant.
// Ports: req (N requests), ptr (search start) -> gnt (one-hot), idx, any.
module multiexp_job_arbiter_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand[IDX_W-1:0];
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiexp_job_arbiter.sv
// Shares one multiexp engine between NUM_REQ requesters: grants jobs round-robin,
// gates the owner's scalar/point streams for exactly num elements, routes results back.
// Latency: data/result paths combinational; grant -> STREAM/ZERO next cycle.
// Backpressure: engine and requester rdy pass straight through; non-owners see rdy=0.
// Ports: i_clk, i_rst (sync, active-high), bus (multiexp_job_arbiter_if.master).
module multiexp_job_arbiter
    import multiexp_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int SCL_BITS = 256,
    parameter int PNT_BITS = 512,
    parameter int RES_BITS = 512
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    multiexp_job_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_BITS-1:0]  num_q;
    logic [CNT_BITS-1:0]  scl_cnt_q;
    logic [CNT_BITS-1:0]  pnt_cnt_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [CNT_BITS-1:0]  grant_num;

    logic                 scl_open, pnt_open;
    logic                 scl_fire, pnt_fire;
    logic                 scl_done_d, pnt_done_d;
    logic                 res_fire, zero_fire;

    multiexp_job_arbiter_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (bus.job_val),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign grant_num = bus.job_num[int'(arb_idx)*CNT_BITS +: CNT_BITS];

    // A stream stays open only until its own count reaches num; the two
    // streams finish independently.
    assign scl_open = (state_q == ST_STREAM) && (scl_cnt_q < num_q);
    assign pnt_open = (state_q == ST_STREAM) && (pnt_cnt_q < num_q);
    assign scl_fire = scl_open && bus.scl_val[owner_q] && bus.eng_scl_rdy;
    assign pnt_fire = pnt_open && bus.pnt_val[owner_q] && bus.eng_pnt_rdy;

    // Look at the post-handshake counts so WAIT_RES is entered the cycle
    // right after the last beat of the later stream.
    assign scl_done_d = ((scl_fire ? scl_cnt_q + 64'd1 : scl_cnt_q) == num_q);
    assign pnt_done_d = ((pnt_fire ? pnt_cnt_q + 64'd1 : pnt_cnt_q) == num_q);

    assign res_fire  = (state_q == ST_WAIT_RES) && bus.eng_res_val && bus.res_rdy[owner_q];
    assign zero_fire = (state_q == ST_ZERO) && bus.res_rdy[owner_q];

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = (grant_num == '0) ? ST_ZERO : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (scl_done_d && pnt_done_d) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (res_fire && bus.eng_res_eop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ZERO: begin
                if (zero_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        bus.job_rdy     = '0;
        bus.scl_rdy     = '0;
        bus.pnt_rdy     = '0;
        bus.num_in      = '0;
        bus.eng_scl_val = 1'b0;
        bus.eng_scl_dat = bus.scl_dat[int'(owner_q)*SCL_BITS +: SCL_BITS];
        bus.eng_pnt_val = 1'b0;
        bus.eng_pnt_dat = bus.pnt_dat[int'(owner_q)*PNT_BITS +: PNT_BITS];
        bus.eng_res_rdy = 1'b0;
        bus.res_val     = '0;
        bus.res_dat     = '0;
        bus.res_sop     = 1'b0;
        bus.res_eop     = 1'b0;
        bus.busy        = (state_q != ST_IDLE);
        bus.owner       = owner_q;

        if (state_q != ST_IDLE) begin
            bus.num_in = num_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A grant during reset would be acknowledged and then lost.
                if (!i_rst) begin
                    bus.job_rdy = arb_gnt;
                end
            end
            ST_STREAM: begin
                bus.eng_scl_val      = scl_open && bus.scl_val[owner_q];
                bus.scl_rdy[owner_q] = scl_open && bus.eng_scl_rdy;
                bus.eng_pnt_val      = pnt_open && bus.pnt_val[owner_q];
                bus.pnt_rdy[owner_q] = pnt_open && bus.eng_pnt_rdy;
            end
            ST_WAIT_RES: begin
                bus.res_val[owner_q] = bus.eng_res_val;
                bus.res_dat          = bus.eng_res_dat;
                bus.res_sop          = bus.eng_res_sop;
                bus.res_eop          = bus.eng_res_eop;
                bus.eng_res_rdy      = bus.res_rdy[owner_q];
            end
            ST_ZERO: begin
                // Empty multiexp: the answer is the point at infinity (all zero).
                bus.res_val[owner_q] = 1'b1;
                bus.res_sop          = 1'b1;
                bus.res_eop          = 1'b1;
            end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            num_q     <= '0;
            scl_cnt_q <= '0;
            pnt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_any) begin
                owner_q   <= arb_idx;
                num_q     <= grant_num;
                scl_cnt_q <= '0;
                pnt_cnt_q <= '0;
            end
            if (scl_fire) begin
                scl_cnt_q <= scl_cnt_q + 64'd1;
            end
            if (pnt_fire) begin
                pnt_cnt_q <= pnt_cnt_q + 64'd1;
            end
            // Job completion: hand priority to the next requester.
            if (state_q != ST_IDLE && state_d == ST_IDLE) begin
                rr_ptr_q <= IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
                num_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_multiexp_job_arbiter.sv
// Directed self-checking bench for multiexp_job_arbiter (NUM_REQ=2).
// The bench plays both requesters and the engine.
module tb_multiexp_job_arbiter;

    localparam int NR = 2;
    localparam int SB = 256;
    localparam int PB = 512;
    localparam int RB = 512;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multiexp_job_arbiter_if #(
        .NUM_REQ(NR), .SCL_BITS(SB), .PNT_BITS(PB), .RES_BITS(RB)
    ) bus ();

    multiexp_job_arbiter #(
        .NUM_REQ(NR), .SCL_BITS(SB), .PNT_BITS(PB), .RES_BITS(RB)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        bus.job_val     = '0;
        bus.job_num     = '0;
        bus.scl_val     = '0;
        bus.scl_dat     = '0;
        bus.pnt_val     = '0;
        bus.pnt_dat     = '0;
        bus.eng_scl_rdy = 1'b0;
        bus.eng_pnt_rdy = 1'b0;
        bus.eng_res_val = 1'b0;
        bus.eng_res_dat = '0;
        bus.eng_res_sop = 1'b0;
        bus.eng_res_eop = 1'b0;
        bus.res_rdy     = '0;
    endtask

    int sent_s, sent_p, fwd_s, fwd_p, rb, cyc;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        clear_inputs();
        bus.job_val = 2'b01;
        repeat (3) tick();
        settle();
        chk("rst_busy",    64'(bus.busy), 64'd0);
        chk("rst_num_in",  bus.num_in, 64'd0);
        chk("rst_job_rdy", 64'(bus.job_rdy), 64'd0);
        chk("rst_owner",   64'(bus.owner), 64'd0);
        chk("rst_res_val", 64'(bus.res_val), 64'd0);
        chk("rst_eng_res_rdy", 64'(bus.eng_res_rdy), 64'd0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // ---------------- single job r0, num=3, 5 scalars offered ----------------
        bus.job_val        = 2'b01;
        bus.job_num[63:0]  = 64'd3;
        settle();
        chk("t1_job_rdy", 64'(bus.job_rdy), 64'd1);
        chk("t1_busy_idle", 64'(bus.busy), 64'd0);
        tick();
        bus.job_val = '0;
        settle();
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_num_in", bus.num_in, 64'd3);
        chk("t1_job_rdy_off", 64'(bus.job_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            bus.scl_val         = 2'b01;
            bus.scl_dat[SB-1:0] = SB'(32'hA0 + i);
            bus.pnt_val         = 2'b01;
            bus.pnt_dat[PB-1:0] = PB'(32'hB0 + i);
            bus.eng_scl_rdy     = 1'b1;
            bus.eng_pnt_rdy     = 1'b1;
            settle();
            chk("t1_eng_scl_val", 64'(bus.eng_scl_val), 64'd1);
            chk("t1_eng_scl_dat", bus.eng_scl_dat[63:0], 64'(32'hA0 + i));
            chk("t1_eng_pnt_dat", bus.eng_pnt_dat[63:0], 64'(32'hB0 + i));
            chk("t1_scl_rdy", 64'(bus.scl_rdy), 64'd1);
            chk("t1_num_in_strm", bus.num_in, 64'd3);
            tick();
        end
        // beats 4 and 5 still offered: must be refused
        bus.scl_dat[SB-1:0] = SB'(32'hA3);
        settle();
        chk("t1_extra_scl_rdy", 64'(bus.scl_rdy), 64'd0);
        chk("t1_extra_eng_val", 64'(bus.eng_scl_val), 64'd0);
        chk("t1_wait_busy", 64'(bus.busy), 64'd1);
        chk("t1_wait_num_in", bus.num_in, 64'd3);
        for (int i = 0; i < 3; i++) begin
            bus.eng_res_val          = 1'b1;
            bus.eng_res_dat[RB-1:0]  = RB'(32'hC0 + i);
            bus.eng_res_sop          = (i == 0);
            bus.eng_res_eop          = (i == 2);
            bus.res_rdy              = 2'b01;
            settle();
            chk("t1_res_val", 64'(bus.res_val), 64'd1);
            chk("t1_res_dat", bus.res_dat[63:0], 64'(32'hC0 + i));
            chk("t1_res_sop", 64'(bus.res_sop), 64'(i == 0));
            chk("t1_res_eop", 64'(bus.res_eop), 64'(i == 2));
            chk("t1_eng_res_rdy", 64'(bus.eng_res_rdy), 64'd1);
            tick();
        end
        // engine offers another beat in IDLE: held off
        bus.eng_res_eop = 1'b0;
        settle();
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);
        chk("t1_idle_eng_res_rdy", 64'(bus.eng_res_rdy), 64'd0);
        chk("t1_idle_res_val", 64'(bus.res_val), 64'd0);
        chk("t1_idle_num_in", bus.num_in, 64'd0);
        chk("t1_idle_scl_rdy", 64'(bus.scl_rdy), 64'd0);

        // ---------------- round robin with num=0 jobs ----------------
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.job_val = 2'b11;
        settle();
        chk("rr_first_grant", 64'(bus.job_rdy), 64'd1);
        tick();
        settle();
        chk("z_busy", 64'(bus.busy), 64'd1);
        chk("z_owner", 64'(bus.owner), 64'd0);
        chk("z_res_val", 64'(bus.res_val), 64'd1);
        chk("z_res_dat", bus.res_dat[63:0], 64'd0);
        chk("z_sop", 64'(bus.res_sop), 64'd1);
        chk("z_eop", 64'(bus.res_eop), 64'd1);
        chk("z_eng_scl_val", 64'(bus.eng_scl_val), 64'd0);
        chk("z_job_rdy", 64'(bus.job_rdy), 64'd0);
        tick();
        settle();
        chk("z_hold_res_val", 64'(bus.res_val), 64'd1);
        bus.res_rdy = 2'b01;
        tick();
        bus.res_rdy = '0;
        settle();
        chk("rr_idle_busy", 64'(bus.busy), 64'd0);
        chk("rr_second_grant", 64'(bus.job_rdy), 64'd2);
        tick();
        settle();
        chk("rr_owner1", 64'(bus.owner), 64'd1);
        chk("rr_res_val1", 64'(bus.res_val), 64'd2);
        bus.res_rdy = 2'b10;
        tick();
        bus.res_rdy = '0;
        settle();
        chk("rr_third_grant", 64'(bus.job_rdy), 64'd1);
        tick();
        bus.job_val = '0;
        bus.res_rdy = 2'b01;
        tick();
        bus.res_rdy = '0;
        settle();
        chk("rr_done_busy", 64'(bus.busy), 64'd0);

        // ---------------- backpressure job r1, num=17 ----------------
        bus.job_val           = 2'b10;
        bus.job_num[127:64]   = 64'd17;
        settle();
        chk("bp_grant", 64'(bus.job_rdy), 64'd2);
        tick();
        bus.job_val = '0;
        sent_s = 0; sent_p = 0; fwd_s = 0; fwd_p = 0; cyc = 0;
        while ((fwd_s < 17 || fwd_p < 17) && cyc < 3000) begin
            bus.scl_val              = {($urandom_range(0, 3) != 0), 1'b0};
            bus.scl_dat[2*SB-1:SB]   = SB'(32'h1000 + sent_s);
            bus.pnt_val              = {($urandom_range(0, 3) != 0), 1'b0};
            bus.pnt_dat[2*PB-1:PB]   = PB'(32'h2000 + sent_p);
            bus.eng_scl_rdy          = 1'($urandom_range(0, 1));
            bus.eng_pnt_rdy          = 1'($urandom_range(0, 1));
            settle();
            if (bus.scl_val[1] && bus.scl_rdy[1]) sent_s++;
            if (bus.pnt_val[1] && bus.pnt_rdy[1]) sent_p++;
            if (bus.eng_scl_val && bus.eng_scl_rdy) begin
                chk("bp_scl_dat", bus.eng_scl_dat[63:0], 64'(32'h1000 + fwd_s));
                fwd_s++;
            end
            if (bus.eng_pnt_val && bus.eng_pnt_rdy) begin
                chk("bp_pnt_dat", bus.eng_pnt_dat[63:0], 64'(32'h2000 + fwd_p));
                fwd_p++;
            end
            tick();
            cyc++;
        end
        chk("bp_fwd_scl", 64'(fwd_s), 64'd17);
        chk("bp_fwd_pnt", 64'(fwd_p), 64'd17);
        chk("bp_sent_scl", 64'(sent_s), 64'd17);
        chk("bp_sent_pnt", 64'(sent_p), 64'd17);
        bus.scl_val     = 2'b10;
        bus.pnt_val     = 2'b10;
        bus.eng_scl_rdy = 1'b1;
        bus.eng_pnt_rdy = 1'b1;
        settle();
        chk("bp_wait_scl_rdy", 64'(bus.scl_rdy), 64'd0);
        chk("bp_wait_eng_pnt_val", 64'(bus.eng_pnt_val), 64'd0);
        chk("bp_wait_num_in", bus.num_in, 64'd17);
        rb = 0; cyc = 0;
        while (rb < 3 && cyc < 300) begin
            bus.eng_res_val         = 1'($urandom_range(0, 1));
            bus.eng_res_dat[RB-1:0] = RB'(32'h3000 + rb);
            bus.eng_res_sop         = (rb == 0);
            bus.eng_res_eop         = (rb == 2);
            bus.res_rdy             = {1'($urandom_range(0, 1)), 1'b0};
            settle();
            if (bus.eng_res_val) chk("bp_res_val", 64'(bus.res_val), 64'd2);
            if (bus.res_val[1] && bus.res_rdy[1]) begin
                chk("bp_res_dat", bus.res_dat[63:0], 64'(32'h3000 + rb));
                chk("bp_res_sop", 64'(bus.res_sop), 64'(rb == 0));
                chk("bp_eng_res_rdy", 64'(bus.eng_res_rdy), 64'd1);
                rb++;
            end
            tick();
            cyc++;
        end
        chk("bp_res_beats", 64'(rb), 64'd3);
        clear_inputs();
        settle();
        chk("bp_end_busy", 64'(bus.busy), 64'd0);

        // ---------------- reset mid-STREAM ----------------
        bus.job_val          = 2'b01;
        bus.job_num[63:0]    = 64'd5;
        settle();
        chk("mr_grant", 64'(bus.job_rdy), 64'd1);
        tick();
        bus.job_val     = '0;
        bus.scl_val     = 2'b01;
        bus.eng_scl_rdy = 1'b1;
        tick();
        tick();
        settle();
        chk("mr_busy_before", 64'(bus.busy), 64'd1);
        rst                 = 1'b1;
        bus.job_val         = 2'b10;
        bus.job_num[127:64] = 64'd1;
        tick();
        settle();
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_num_in", bus.num_in, 64'd0);
        chk("mr_scl_rdy", 64'(bus.scl_rdy), 64'd0);
        chk("mr_eng_scl_val", 64'(bus.eng_scl_val), 64'd0);
        chk("mr_job_rdy_in_rst", 64'(bus.job_rdy), 64'd0);
        chk("mr_owner", 64'(bus.owner), 64'd0);
        rst = 1'b0;
        settle();
        chk("mr_new_grant", 64'(bus.job_rdy), 64'd2);
        tick();
        bus.job_val = '0;
        settle();
        chk("mr_new_busy", 64'(bus.busy), 64'd1);
        chk("mr_new_owner", 64'(bus.owner), 64'd1);
        chk("mr_new_num_in", bus.num_in, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiexp_job_arbiter.md
# multiexp_job_arbiter

Round-robin arbiter and job sequencer that shares one multi-exponentiation engine (the Fp2/G2 multiexp wrapper or its G1 equivalent) between NUM_REQ requesters. It grants one job at a time, drives the engine's element count, gates each requester's scalar and point streams into the engine for exactly the job's element count, and routes the engine's result beats back to the owning requester. It sits between the host/DMA stream sources and the multiexp wrapper.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- SCL_BITS, 256: scalar beat width.
- PNT_BITS, 512: point beat width.
- RES_BITS, 512: result beat width.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high; clock i_clk.
- i_job_val  in  NUM_REQ  job request per requester.
- i_job_num  in  NUM_REQ*64  element count per requester; slice r at [r*64 +: 64].
- o_job_rdy  out  NUM_REQ  job accepted this cycle (one-hot or zero).
- i_scl_val / i_scl_dat / o_scl_rdy  in/in/out  NUM_REQ / NUM_REQ*SCL_BITS / NUM_REQ  per-requester scalar streams.
- i_pnt_val / i_pnt_dat / o_pnt_rdy  in/in/out  NUM_REQ / NUM_REQ*PNT_BITS / NUM_REQ  per-requester point streams.
- o_num_in  out  64  element count to engine.
- o_eng_scl_val / o_eng_scl_dat / i_eng_scl_rdy  out/out/in  1 / SCL_BITS / 1  engine scalar stream.
- o_eng_pnt_val / o_eng_pnt_dat / i_eng_pnt_rdy  out/out/in  1 / PNT_BITS / 1  engine point stream.
- i_eng_res_val / i_eng_res_dat / i_eng_res_sop / i_eng_res_eop / o_eng_res_rdy  in/in/in/in/out  1 / RES_BITS / 1 / 1 / 1  engine result stream.
- o_res_val / o_res_dat / o_res_sop / o_res_eop / i_res_rdy  out/out/out/out/in  NUM_REQ / RES_BITS / 1 / 1 / NUM_REQ  result to requesters (dat/sop/eop shared, val one-hot).
- o_busy  out  1  state != IDLE.
- o_owner  out  $clog2(NUM_REQ)  current grant index.

## Operation
- States: IDLE, STREAM, WAIT_RES, ZERO.
- IDLE: pick first r with i_job_val[r], searching from rr_ptr upward with wrap. Assert o_job_rdy[r] that cycle; latch owner=r, num=i_job_num[r], clear scl_cnt and pnt_cnt. num!=0 -> STREAM; num==0 -> ZERO.
- STREAM: owner scalar stream muxed combinationally to engine while scl_cnt<num; same for points with pnt_cnt. Each counter increments on its own val&&rdy handshake. Non-owners and an owner whose count is reached see rdy=0; engine val forced 0. When both counts equal num -> WAIT_RES.
- WAIT_RES: engine result passed combinationally to owner: o_res_val[owner]=i_eng_res_val, o_eng_res_rdy=i_res_rdy[owner]. On handshake with eop -> IDLE, rr_ptr=owner+1 mod NUM_REQ.
- ZERO: present single beat to owner, dat=0 (point at infinity), sop=eop=1; on i_res_rdy[owner] -> IDLE, rr_ptr advances.
- Engine result beats arriving in IDLE/STREAM/ZERO: o_eng_res_rdy=0 (held off, never dropped).
- o_num_in = latched num from grant until return to IDLE; 0 in IDLE.
- Counters 64-bit, no wrap; num up to 2^64-1.

## Timing
- Reset: state IDLE, rr_ptr=0, owner=0, num=0, counters 0; all val/rdy outputs 0, o_busy=0, o_num_in=0.
- Grant: o_job_rdy combinational in IDLE; STREAM/ZERO from next cycle. Minimum one IDLE cycle between jobs.
- Data/result paths: zero latency (combinational mux); state, counters, owner registered.
- Final beat of last-completing stream and WAIT_RES entry: next cycle. Scalar/point counts complete independently in any order.
- Simultaneous requests: one grant per IDLE cycle, round-robin; the owner cannot win again while another requester is waiting.
- Reset mid-job: immediate return to IDLE; partial job is discarded, engine must be reset with the same i_rst.

## Structure
- Control logic only, no datapath arithmetic. bn128_pkg unchanged; widths come from parameters.
- One sub-module: rr_arbiter (NUM_REQ request vector, rr_ptr -> one-hot grant + index), reusable elsewhere.

## Test plan
- Single job r0, num=3, engine ready always -> exactly 3 scalar and 3 point beats forwarded, o_num_in=3 throughout, 3-beat result (sop beat 0, eop beat 2) only on o_res_val[0].
- r0 and r1 request together after reset -> r0 granted first, r1 next; requests raised again -> r0 granted after r1 finishes.
- Requester offers 5 scalars for num=3 -> beats 4 and 5 not accepted (o_scl_rdy=0) until the next job.
- num=0 job -> no engine beats, one result beat dat=0, sop=eop=1, then IDLE.
- Random backpressure on engine rdy and i_res_rdy, num=17 -> no beat lost or duplicated, result order preserved.
- i_rst asserted mid-STREAM at scl_cnt=2 -> next cycle all outputs at reset values, o_busy=0, new job accepted normally.
